// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of N_CH output channels with shadow/commit, a saturating write counter and error pulse.
// Define MMIO_PORT_BANK_TRACE_EN to print one trace line per accepted write (simulation only).
module mmio_port_bank #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                OUT_W     = 16,
    parameter int                N_CH      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h20,
    parameter int                STRIDE    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic [N_CH*OUT_W-1:0] ch_out,
    output logic [N_CH-1:0]       ch_upd,
    output logic                  err
);

    localparam int                SHIFT    = $clog2(STRIDE);
    localparam logic [ADDR_W-1:0] WIN      = ADDR_W'((N_CH + 2) * STRIDE);
    localparam logic [ADDR_W-1:0] ALIGN_M  = ADDR_W'(STRIDE - 1);
    localparam logic [ADDR_W-1:0] CTRL_REG = ADDR_W'(N_CH);
    localparam logic [ADDR_W-1:0] WCNT_REG = ADDR_W'(N_CH + 1);

    logic [OUT_W-1:0]  sh_q [N_CH];
    logic [OUT_W-1:0]  sh_d [N_CH];
    logic [OUT_W-1:0]  ch_q [N_CH];
    logic [OUT_W-1:0]  ch_d [N_CH];
    logic [N_CH-1:0]   dirty_q, dirty_d;
    logic              shen_q, shen_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [N_CH-1:0]   upd_d;
    logic              err_d;
    logic [DATA_W-1:0] rd_d;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] reg_num;
    logic              in_win, aligned, hit;
    logic [N_CH-1:0]   hit_ch;
    logic              is_ctrl, is_wcnt, commit;
    logic              unused_wdata;

    assign unused_wdata = ^wdata;

    // Address decode; offset is only meaningful when addr >= BASE_ADDR.
    assign offset  = addr - BASE_ADDR;
    assign reg_num = offset >> SHIFT;
    assign in_win  = (addr >= BASE_ADDR) && (offset < WIN);
    assign aligned = (offset & ALIGN_M) == '0;
    assign hit     = in_win && aligned;
    assign is_ctrl = hit && (reg_num == CTRL_REG);
    assign is_wcnt = hit && (reg_num == WCNT_REG);
    // Explicit COMMIT bit, or SHADOW falling 1->0, both flush the dirty channels.
    assign commit  = we && is_ctrl && (wdata[1] || (shen_q && !wdata[0]));

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            hit_ch[i] = hit && (reg_num == ADDR_W'(i));
        end
    end

    always_comb begin
        sh_d    = sh_q;
        ch_d    = ch_q;
        dirty_d = dirty_q;
        shen_d  = shen_q;
        wcnt_d  = wcnt_q;
        upd_d   = '0;
        err_d   = in_win && !aligned && (we || re);
        if (we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (hit_ch[i]) begin
                    sh_d[i] = wdata[OUT_W-1:0];
                    if (shen_q) begin
                        dirty_d[i] = 1'b1;
                    end else begin
                        ch_d[i]  = wdata[OUT_W-1:0];
                        upd_d[i] = 1'b1;
                    end
                    if (wcnt_q != 16'hFFFF) begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end
            end
            if (is_ctrl) begin
                shen_d = wdata[0];
            end
            if (commit) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (dirty_q[i]) begin
                        ch_d[i] = sh_q[i];
                    end
                end
                upd_d   = dirty_q;
                dirty_d = '0;
            end
            if (is_wcnt) begin
                wcnt_d = '0;
            end
        end
    end

    // Readback uses pre-write state so a same-cycle read/write sees the old value.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit_ch[i]) begin
                rd_d = DATA_W'(sh_q[i]);
            end
        end
        if (is_ctrl) begin
            rd_d = DATA_W'(shen_q);
        end
        if (is_wcnt) begin
            rd_d = DATA_W'(wcnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '{default: '0};
            ch_q    <= '{default: '0};
            dirty_q <= '0;
            shen_q  <= 1'b0;
            wcnt_q  <= '0;
            ch_upd  <= '0;
            err     <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            sh_q    <= sh_d;
            ch_q    <= ch_d;
            dirty_q <= dirty_d;
            shen_q  <= shen_d;
            wcnt_q  <= wcnt_d;
            ch_upd  <= upd_d;
            err     <= err_d;
            rvalid  <= re;
            rdata   <= re ? rd_d : '0;
        end
    end

    always_comb begin
        ch_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_out[i*OUT_W +: OUT_W] = ch_q[i];
        end
    end

`ifdef MMIO_PORT_BANK_TRACE_EN
    logic [N_CH*OUT_W-1:0] trace_ch;

    always_comb begin
        trace_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            trace_ch[i*OUT_W +: OUT_W] = ch_d[i];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (we && hit) begin
                $display("%0t mmio_port_bank wr addr=%h wdata=%h reg=%s ch_out=%h", $time, addr, wdata,
                         is_ctrl ? "CTRL" : (is_wcnt ? "WCNT" : "CH"), trace_ch);
            end
            if (err_d) begin
                $display("%0t mmio_port_bank ERR addr=%h wdata=%h", $time, addr, wdata);
            end
        end
    end
`endif

endmodule
